// File: rtl/asip_pkg.sv
// Shared encodings for the 17-bit ASIP control path: opcode and condition
// fields, datapath select constants and the control FSM state type.
package asip_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    C_AL = 3'b000,
    C_EQ = 3'b001,
    C_NE = 3'b010,
    C_LT = 3'b011,
    C_GE = 3'b100,
    C_MI = 3'b101,
    C_PL = 3'b110,
    C_NV = 3'b111
  } cond_e;

  localparam logic [1:0] ALU_SUM = 2'b00;
  localparam logic [1:0] ALU_RST = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_ALU = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] REGSRC_NONE  = 2'b00;
  localparam logic [1:0] REGSRC_BR    = 2'b01;
  localparam logic [1:0] REGSRC_STORE = 2'b10;

  typedef enum logic {
    S_EXEC  = 1'b0,
    S_MWAIT = 1'b1
  } state_e;

endpackage

// File: rtl/asip_cond_check.sv
// Branch condition evaluator: compares a 3-bit condition code against an
// {N,Z,C,V} flag vector and reports whether the branch is taken.
module asip_cond_check
  import asip_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, v;
  logic unused_c;

  assign n        = flags[3];
  assign z        = flags[2];
  assign v        = flags[0];
  assign unused_c = flags[1];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      C_AL:    pass = 1'b1;
      C_EQ:    pass = z;
      C_NE:    pass = ~z;
      C_LT:    pass = (n != v);
      C_GE:    pass = (n == v);
      C_MI:    pass = n;
      C_PL:    pass = ~n;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/asip_control_unit.sv
// ASIP control unit: instruction decode, registered NZCV flags, and a two-state
// FSM that stalls the PC on data-memory accesses with an optional watchdog.
module asip_control_unit
  import asip_pkg::*;
#(
  parameter int IW       = 17,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] Instr,
  input  logic [3:0]    ALUFlags,
  input  logic          mem_ready,
  output logic [1:0]    RegSrc,
  output logic          RegWrite,
  output logic [1:0]    ImmSrc,
  output logic          ALUSrc,
  output logic [1:0]    ALUControl,
  output logic          MemWrite,
  output logic          MemtoReg,
  output logic          PCSrc,
  output logic          PCEn,
  output logic          mem_req,
  output logic          mem_error,
  output logic          illegal
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  state_e        state_q, state_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  op_e  op;
  logic is_load;
  logic cond_pass;
  logic unused_instr;

  assign op           = op_e'(Instr[16:15]);
  assign is_load      = Instr[12];
  assign unused_instr = ^Instr[10:0];

  asip_cond_check u_cond (
    .cond  (Instr[13:11]),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    RegSrc     = REGSRC_NONE;
    RegWrite   = 1'b0;
    ImmSrc     = IMM_ALU;
    ALUSrc     = 1'b0;
    ALUControl = ALU_SUM;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 1'b0;
    PCEn       = 1'b1;
    mem_req    = 1'b0;
    mem_error  = 1'b0;
    illegal    = 1'b0;
    state_d    = S_EXEC;
    flags_d    = flags_q;
    wait_cnt_d = wait_cnt_q;

    case (op)
      OP_DP: begin
        RegWrite   = 1'b1;
        ALUSrc     = Instr[14];
        ALUControl = Instr[13:12];
        flags_d    = ALUFlags;
      end
      OP_MEM: begin
        ImmSrc  = IMM_MEM;
        ALUSrc  = 1'b1;
        mem_req = 1'b1;
        if (is_load) begin
          MemtoReg = 1'b1;
        end else begin
          RegSrc   = REGSRC_STORE;
          MemWrite = 1'b1;
        end
        // Stall sequencing: the instruction is held upstream while PCEn is low.
        if (mem_ready) begin
          RegWrite = is_load;
        end else if (state_q == S_EXEC) begin
          PCEn       = 1'b0;
          state_d    = S_MWAIT;
          wait_cnt_d = '0;
        end else if ((MAX_WAIT > 0) && (wait_cnt_q == WAIT_LIM)) begin
          mem_error = 1'b1;
          mem_req   = 1'b0;
        end else begin
          PCEn       = 1'b0;
          state_d    = S_MWAIT;
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      OP_BR: begin
        RegSrc = REGSRC_BR;
        ImmSrc = IMM_BR;
        ALUSrc = 1'b1;
        PCSrc  = cond_pass;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (reset) begin
      RegSrc     = 2'b00;
      RegWrite   = 1'b0;
      ImmSrc     = 2'b00;
      ALUSrc     = 1'b0;
      ALUControl = 2'b00;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      PCSrc      = 1'b0;
      PCEn       = 1'b0;
      mem_req    = 1'b0;
      mem_error  = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EXEC;
      flags_q    <= 4'b0000;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_asip_control_unit.sv
// Bench for asip_control_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_asip_control_unit;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemWrite, MemtoReg, PCSrc, PCEn;
  logic        mem_req, mem_error, illegal;

  asip_control_unit #(.IW(17), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .RegSrc(RegSrc), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCEn(PCEn),
    .mem_req(mem_req), .mem_error(mem_error), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Packed view: RegSrc,RegWrite,ImmSrc,ALUSrc,ALUControl,MemWrite,MemtoReg,PCSrc,PCEn,mem_req,mem_error,illegal
  logic [14:0] dut_vec;
  assign dut_vec = {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite,
                    MemtoReg, PCSrc, PCEn, mem_req, mem_error, illegal};

  int n_chk = 0;
  int n_fail = 0;
  int cycle = 0;

  logic        chk_en = 1'b0;
  logic [14:0] exp_vec = '0;
  logic [16:0] cur_instr = '0;
  logic [3:0]  cur_af = '0;
  logic        cur_rdy = 1'b0;
  logic        cur_rst = 1'b1;
  logic [3:0]  m_flags = '0;
  int          m_age = 0;

  function automatic logic cond_ok(input logic [2:0] c, input logic [3:0] fl);
    logic n, z, v;
    n = fl[3]; z = fl[2]; v = fl[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n ^ v;
      3'd4: return !(n ^ v);
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // age = number of cycles this memory instruction has already been presented
  function automatic logic [14:0] model(input logic [16:0] in, input logic [3:0] fl,
                                        input int age, input logic rdy, input logic rs);
    logic [14:0] o;
    logic to;
    o = '0;
    if (rs) return o;
    case (in[16:15])
      2'b00: begin
        o[12] = 1'b1; o[9] = in[14]; o[8:7] = in[13:12]; o[3] = 1'b1;
      end
      2'b01: begin
        to = !rdy && (MAXW > 0) && (age == MAXW + 1);
        o[11:10] = 2'b01; o[9] = 1'b1; o[2] = !to; o[3] = rdy || to; o[1] = to;
        if (in[12]) begin
          o[5] = 1'b1; o[12] = rdy;
        end else begin
          o[14:13] = 2'b10; o[6] = 1'b1;
        end
      end
      2'b10: begin
        o[14:13] = 2'b01; o[11:10] = 2'b10; o[9] = 1'b1; o[3] = 1'b1;
        o[4] = cond_ok(in[13:11], fl);
      end
      default: begin
        o[3] = 1'b1; o[0] = 1'b1;
      end
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL model cycle %0d instr=%b: dut=%b expected=%b", cycle, cur_instr, dut_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic cyc(input logic [16:0] in, input logic [3:0] af, input logic rdy, input logic rs);
    @(posedge clk);
    if (chk_en) begin
      if (cur_rst) begin
        m_flags = '0;
        m_age = 0;
      end else begin
        if (cur_instr[16:15] == 2'b00) m_flags = cur_af;
        if (cur_instr[16:15] == 2'b01 && !exp_vec[3]) m_age++;
        else m_age = 0;
      end
    end
    #1;
    Instr = in; ALUFlags = af; mem_ready = rdy; reset = rs;
    cur_instr = in; cur_af = af; cur_rdy = rdy; cur_rst = rs;
    exp_vec = model(in, m_flags, m_age, rdy, rs);
    chk_en = 1'b1;
    cycle++;
    #3;
  endtask

  localparam logic [16:0] I_MOVI  = 17'b00_1_00_1110_0010_0010;
  localparam logic [16:0] I_STORE = 17'b01_00_0_0001_0010_0000;
  localparam logic [16:0] I_LOAD  = 17'b01_00_1_0001_0100_0000;
  localparam logic [16:0] I_RST   = 17'b00_0_01_0000_0000_0000;
  localparam logic [16:0] I_BEQ   = 17'b10_0_001_00000000000;
  localparam logic [16:0] I_BNE   = 17'b10_0_010_00000000000;
  localparam logic [16:0] I_BAL   = 17'b10_0_000_00000000001;

  initial begin
    logic [16:0] ni;
    logic        stubborn;
    logic        rd;
    logic        rs;

    cyc(17'd0, 4'b0000, 1'b0, 1'b1);
    chk("reset_outputs", dut_vec, 15'd0);
    cyc(17'd0, 4'b0000, 1'b0, 1'b0);
    chk("sum_r0_regwrite_pcen", {13'd0, RegWrite, PCEn}, 15'b11);
    chk("sum_r0_pcsrc_rst_flags", {14'd0, PCSrc}, 15'd0);

    cyc(I_MOVI, 4'b0000, 1'b0, 1'b0);
    chk("movi", {8'd0, RegSrc, ImmSrc, ALUSrc, ALUControl, RegWrite}, {8'd0, 7'b00_00_1_00, 1'b1});

    for (int i = 0; i < 4; i++) begin
      cyc(I_STORE, 4'b0000, (i == 3), 1'b0);
      chk($sformatf("store_stall_%0d", i), {11'd0, mem_req, MemWrite, PCEn, RegWrite},
          {11'd0, 1'b1, 1'b1, (i == 3), 1'b0});
    end

    cyc(I_LOAD, 4'b0000, 1'b1, 1'b0);
    chk("load_ready", {12'd0, MemtoReg, RegWrite, PCEn}, 15'b111);

    cyc(I_RST, 4'b0100, 1'b0, 1'b0);
    cyc(I_BEQ, 4'b0000, 1'b0, 1'b0);
    chk("beq_taken", {14'd0, PCSrc}, 15'd1);
    cyc(I_BNE, 4'b0000, 1'b0, 1'b0);
    chk("bne_not_taken", {14'd0, PCSrc}, 15'd0);
    cyc(I_BAL, 4'b1111, 1'b0, 1'b0);
    chk("bal_taken", {14'd0, PCSrc}, 15'd1);

    for (int i = 0; i <= MAXW + 1; i++) begin
      cyc(I_LOAD, 4'b0000, 1'b0, 1'b0);
      if (i == MAXW)
        chk("load_before_timeout", {11'd0, mem_error, PCEn, mem_req, RegWrite}, 15'b0010);
    end
    chk("load_timeout", {11'd0, mem_error, RegWrite, PCEn, mem_req}, 15'b1010);

    for (int i = 0; i < 5; i++) cyc(I_LOAD, 4'b0000, 1'b0, 1'b0);
    cyc(I_LOAD, 4'b0000, 1'b0, 1'b1);
    chk("reset_mid_stall", dut_vec, 15'd0);
    cyc(I_LOAD, 4'b0000, 1'b0, 1'b0);
    chk("after_reset_fresh_stall", {12'd0, PCEn, mem_req, mem_error}, 15'b010);
    cyc(I_LOAD, 4'b0000, 1'b1, 1'b0);

    ni = '0;
    stubborn = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (cur_rst || exp_vec[3]) begin
        ni = 17'($urandom);
        stubborn = ($urandom_range(0, 9) == 0);
      end
      rd = stubborn ? 1'b0 : ($urandom_range(0, 9) < 3);
      rs = ($urandom_range(0, 199) == 0);
      cyc(ni, 4'($urandom), rd, rs);
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
